// File: rtl/buffer_readout_pkg.sv
// Shared constants for the raw-hits buffer readout: FSM encodings and header-word layout.
package buffer_readout_pkg;

   // Readout FSM encodings.
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETTLE = 3'd1,
      ST_LATCH  = 3'd2,
      ST_HDR    = 3'd3,
      ST_DATA   = 3'd4,
      ST_POP    = 3'd5
   } state_e;

   // Header word: 32-bit event tag in the low bits, zero-extended to the word width.
   localparam int TAG_W       = 32;
   localparam int HDR_TAG_LSB = 0;

   // Build the tag field of a header word.
   function automatic logic [TAG_W-1:0] hdr_tag_field(input logic [TAG_W-1:0] tag);
      return tag;
   endfunction

endpackage

// File: rtl/buffer_readout_if.sv
// Bus bundle between the readout block and its fence queue, hits RAM and output stream.
interface buffer_readout_if #(
   parameter int ADRB  = 11,
   parameter int DATAW = 32,
   parameter int FQW   = ADRB + 32
) ();
   logic             fq_empty;
   logic [FQW-1:0]   fq_rd_data;
   logic             fq_pop;
   logic             buf_rd_en;
   logic [ADRB-1:0]  buf_rd_adr;
   logic [DATAW-1:0] buf_rd_data;
   logic [DATAW-1:0] out_data;
   logic             out_valid;
   logic             out_ready;
   logic             out_first;
   logic             out_last;
   logic [ADRB-1:0]  free_adr;
   logic             busy;
   logic             sump;

   modport master (
      input  fq_empty, fq_rd_data, buf_rd_data, out_ready,
      output fq_pop, buf_rd_en, buf_rd_adr, out_data, out_valid,
             out_first, out_last, free_adr, busy, sump
   );

   modport slave (
      output fq_empty, fq_rd_data, buf_rd_data, out_ready,
      input  fq_pop, buf_rd_en, buf_rd_adr, out_data, out_valid,
             out_first, out_last, free_adr, busy, sump
   );
endinterface

// File: rtl/buffer_readout_skid.sv
// Two-entry skid FIFO holding words returned by the hits RAM (plus first/last flags).
module readout_skid #(
   parameter int W = 34
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] push_data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [W-1:0] head_o
);
   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q, wr_ptr_d;
   logic         rd_ptr_q, rd_ptr_d;
   logic [1:0]   count_q, count_d;
   logic         do_push_s, do_pop_s;

   assign do_push_s = push_i && (count_q != 2'd2);
   assign do_pop_s  = pop_i && (count_q != 2'd0);

   // Pointer and occupancy next-state.
   always_comb begin
      wr_ptr_d = do_push_s ? ~wr_ptr_q : wr_ptr_q;
      rd_ptr_d = do_pop_s ? ~rd_ptr_q : rd_ptr_q;
      count_d  = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
   end

   // Storage, pointers and occupancy registers; reset flushes the buffer.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         mem_q[0]  <= '0;
         mem_q[1]  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_data_i;
         end
      end
   end

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/buffer_readout.sv
// Reads one event per fence-queue entry out of the raw hits ring buffer:
// a tag header followed by the words from start_adr up to (excluding) the fence.
module buffer_readout
   import buffer_readout_pkg::*;
#(
   parameter int ADRB  = 11,
   parameter int DATAW = 32,
   parameter int FQW   = ADRB + 32
) (
   input logic             clock,
   input logic             reset,
   buffer_readout_if.master bus
);
   localparam int SKW = DATAW + 2;

   state_e           state_q, state_d;
   logic [ADRB-1:0]  start_adr_q, start_adr_d;
   logic [ADRB-1:0]  free_adr_q, free_adr_d;
   logic [ADRB-1:0]  fence_q, fence_d;
   logic [ADRB-1:0]  rd_adr_q, rd_adr_d;
   logic             inflight_q, inflight_d;
   logic             inflight_last_q, inflight_last_d;

   logic [ADRB-1:0]  fq_fence_s, len_s, rd_adr_inc_s;
   logic [TAG_W-1:0] fq_tag_s;
   logic [DATAW-1:0] hdr_word_s;
   logic             sk_push_s, sk_full_s, sk_empty_s;
   logic [SKW-1:0]   sk_push_data_s, sk_head_s;
   logic [1:0]       sk_count_s;
   logic [2:0]       occ_s;
   logic             accept_s, issue_s, head_first_s, head_last_s, sump_s;

   assign fq_fence_s   = bus.fq_rd_data[ADRB-1:0];
   assign fq_tag_s     = bus.fq_rd_data[ADRB+TAG_W-1:ADRB];
   assign len_s        = fq_fence_s - start_adr_q;
   assign rd_adr_inc_s = rd_adr_q + ADRB'(1);
   assign head_first_s = sk_head_s[DATAW+1];
   assign head_last_s  = sk_head_s[DATAW];
   assign accept_s     = !sk_empty_s && bus.out_ready;
   assign sk_count_s   = sk_full_s ? 2'd2 : (sk_empty_s ? 2'd0 : 2'd1);

   // Occupancy counts the word leaving this cycle as gone, so one read per cycle
   // is sustained at full rate while never overrunning the 2-entry skid.
   assign occ_s   = {1'b0, sk_count_s} + {2'b0, inflight_q} - {2'b0, accept_s};
   assign issue_s = (state_q == ST_DATA) && (rd_adr_q != fence_q) && (occ_s < 3'd2);

   // Bits of the fence entry above the tag are not used.
   if (FQW > ADRB + TAG_W) begin : g_sump_wide
      assign sump_s = |bus.fq_rd_data[FQW-1:ADRB+TAG_W];
   end else begin : g_sump_none
      assign sump_s = 1'b0;
   end

   // Zero-extended header word carrying the event tag.
   always_comb begin
      hdr_word_s = '0;
      hdr_word_s[HDR_TAG_LSB +: TAG_W] = hdr_tag_field(fq_tag_s);
   end

   // Skid input: header enters at LATCH, RAM words enter one cycle after their read.
   always_comb begin
      sk_push_s      = 1'b0;
      sk_push_data_s = '0;
      if (state_q == ST_LATCH) begin
         sk_push_s      = 1'b1;
         sk_push_data_s = {1'b1, (len_s == '0), hdr_word_s};
      end else if (inflight_q) begin
         sk_push_s      = 1'b1;
         sk_push_data_s = {1'b0, inflight_last_q, bus.buf_rd_data};
      end else begin
         sk_push_s      = 1'b0;
      end
   end

   readout_skid #(.W(SKW)) u_skid (
      .clock       (clock),
      .reset       (reset),
      .push_i      (sk_push_s),
      .push_data_i (sk_push_data_s),
      .pop_i       (accept_s),
      .full_o      (sk_full_s),
      .empty_o     (sk_empty_s),
      .head_o      (sk_head_s)
   );

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state: the out_last flag on the accepted word ends the event.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   state_d = bus.fq_empty ? ST_IDLE : ST_SETTLE;
         ST_SETTLE: state_d = ST_LATCH;
         ST_LATCH:  state_d = ST_HDR;
         ST_HDR:    state_d = accept_s ? (head_last_s ? ST_POP : ST_DATA) : ST_HDR;
         ST_DATA:   state_d = (accept_s && head_last_s) ? ST_POP : ST_DATA;
         ST_POP:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state: fence capture, read address walk, release at POP.
   always_comb begin
      start_adr_d     = start_adr_q;
      free_adr_d      = free_adr_q;
      fence_d         = fence_q;
      rd_adr_d        = rd_adr_q;
      inflight_d      = issue_s;
      inflight_last_d = inflight_last_q;
      case (state_q)
         ST_LATCH: begin
            fence_d  = fq_fence_s;
            rd_adr_d = start_adr_q;
         end
         ST_DATA: begin
            if (issue_s) begin
               rd_adr_d        = rd_adr_inc_s;
               inflight_last_d = (rd_adr_inc_s == fence_q);
            end else begin
               rd_adr_d        = rd_adr_q;
            end
         end
         ST_POP: begin
            start_adr_d = fence_q;
            free_adr_d  = fence_q;
         end
         default: begin
            rd_adr_d = rd_adr_q;
         end
      endcase
   end

   // Datapath registers; reset abandons any event and restarts from address 0.
   always_ff @(posedge clock) begin
      if (reset) begin
         start_adr_q     <= '0;
         free_adr_q      <= '0;
         fence_q         <= '0;
         rd_adr_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         start_adr_q     <= start_adr_d;
         free_adr_q      <= free_adr_d;
         fence_q         <= fence_d;
         rd_adr_q        <= rd_adr_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
      end
   end

   // FSM outputs; stream outputs come straight from the skid head register.
   always_comb begin
      bus.fq_pop     = (state_q == ST_POP) && !bus.fq_empty;
      bus.buf_rd_en  = issue_s;
      bus.buf_rd_adr = rd_adr_q;
      bus.out_valid  = !sk_empty_s;
      bus.out_data   = sk_head_s[DATAW-1:0];
      bus.out_first  = !sk_empty_s && head_first_s;
      bus.out_last   = !sk_empty_s && head_last_s;
      bus.free_adr   = free_adr_q;
      bus.busy       = (state_q != ST_IDLE);
      bus.sump       = sump_s;
   end
endmodule

// File: tb/tb_buffer_readout.sv
// Directed bench for buffer_readout with a scoreboard queue of expected stream words.
module tb_buffer_readout;
   import buffer_readout_pkg::*;

   localparam int ADRB  = 11;
   localparam int DATAW = 32;
   localparam int FQW   = ADRB + 32;
   localparam int DEPTH = 1 << ADRB;

   logic clock = 1'b0;
   logic reset;

   buffer_readout_if #(.ADRB(ADRB), .DATAW(DATAW), .FQW(FQW)) bus ();

   buffer_readout #(.ADRB(ADRB), .DATAW(DATAW), .FQW(FQW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   // Hits RAM model: one cycle read latency.
   logic [DATAW-1:0] mem [DEPTH];
   always @(posedge clock) begin
      if (bus.buf_rd_en) bus.buf_rd_data <= mem[bus.buf_rd_adr];
   end

   logic [DATAW+1:0] exp_q [$];
   logic [FQW-1:0]   fq [$];
   int total, bad, cyc, pops, hdrs, ev_data, issued, data_acc, last_pop;
   int p0, h0;
   logic             stall_q;
   logic [DATAW+1:0] held;
   logic [ADRB-1:0]  exp_start;
   bit               reached;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic fq_drive();
      bus.fq_empty   = (fq.size() == 0);
      bus.fq_rd_data = (fq.size() != 0) ? fq[0] : '0;
   endtask

   // Observes the DUT at the falling edge, i.e. the values the next rising edge acts on.
   task automatic monitor();
      logic [DATAW+1:0] w;
      cyc++;
      w = {bus.out_first, bus.out_last, bus.out_data};
      if (reset) begin
         stall_q  = 1'b0;
         issued   = 0;
         data_acc = 0;
      end else begin
         if (stall_q) chk("stall_stable", {31'd0, bus.out_valid, w}, {31'd0, 1'b1, held});
         stall_q = bus.out_valid && !bus.out_ready;
         held    = w;
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) chk("spurious_word", 64'(exp_q.size()), 64'd1);
            else chk("word", 64'(w), 64'(exp_q.pop_front()));
            if (bus.out_first) hdrs++;
            else begin
               ev_data++;
               data_acc++;
            end
         end
         if (bus.buf_rd_en) begin
            issued++;
            chk("outstanding_le2", 64'(issued - data_acc <= 2), 64'd1);
         end
         if (bus.fq_pop) begin
            chk("pop_nonempty", 64'(bus.fq_empty), 64'd0);
            pops++;
            last_pop = cyc;
            if (fq.size() != 0) void'(fq.pop_front());
         end
         if (dut.state_q == ST_LATCH) chk("latch_gap", 64'(cyc - last_pop >= 3), 64'd1);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      monitor();
      @(posedge clock);
      #1;
      fq_drive();
   endtask

   task automatic push_event(input logic [ADRB-1:0] fence, input logic [31:0] tag);
      logic [ADRB-1:0] len;
      len = fence - exp_start;
      exp_q.push_back({1'b1, (len == '0), tag});
      for (int i = 0; i < int'(len); i++) begin
         logic [ADRB-1:0] a;
         a = exp_start + ADRB'(i);
         exp_q.push_back({1'b0, (i == int'(len) - 1), mem[a]});
      end
      exp_start = fence;
      fq.push_back({tag, fence});
      fq_drive();
      ev_data = 0;
   endtask

   task automatic wait_done(input int budget, input bit rnd);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         if (exp_q.size() == 0 && fq.size() == 0 && !bus.busy) done = 1'b1;
         else begin
            if (rnd) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
         end
      end
      bus.out_ready = 1'b1;
      chk("completion", 64'(done), 64'd1);
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0; pops = 0; hdrs = 0; ev_data = 0;
      issued = 0; data_acc = 0; last_pop = -100;
      stall_q = 1'b0; held = '0; exp_start = '0;
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom();
      reset = 1'b1;
      bus.out_ready = 1'b1;
      fq_drive();
      repeat (3) tick();

      // Reset state
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_first", 64'(bus.out_first), 64'd0);
      chk("rst_out_last",  64'(bus.out_last),  64'd0);
      chk("rst_fq_pop",    64'(bus.fq_pop),    64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_rd_en",     64'(bus.buf_rd_en), 64'd0);
      chk("rst_free_adr",  64'(bus.free_adr),  64'd0);
      reset = 1'b0;
      tick();

      // Single event 0..3
      p0 = pops; h0 = hdrs;
      push_event(11'd4, 32'hA5A5_0001);
      wait_done(200, 1'b0);
      chk("ev1_data", 64'(ev_data), 64'd4);
      chk("ev1_pops", 64'(pops - p0), 64'd1);
      chk("ev1_hdrs", 64'(hdrs - h0), 64'd1);
      chk("ev1_free", 64'(bus.free_adr), 64'd4);

      // Long event bringing start to 2045, then a wrapping event
      push_event(11'd2045, 32'h0000_0002);
      wait_done(5000, 1'b0);
      chk("long_data", 64'(ev_data), 64'd2041);
      chk("long_free", 64'(bus.free_adr), 64'd2045);
      push_event(11'd3, 32'h0000_0003);
      wait_done(200, 1'b0);
      chk("wrap_data", 64'(ev_data), 64'd6);
      chk("wrap_free", 64'(bus.free_adr), 64'd3);

      // Header-only event
      p0 = pops; h0 = hdrs;
      push_event(11'd3, 32'h0000_0004);
      wait_done(100, 1'b0);
      chk("zero_data", 64'(ev_data), 64'd0);
      chk("zero_hdrs", 64'(hdrs - h0), 64'd1);
      chk("zero_pops", 64'(pops - p0), 64'd1);
      chk("zero_free", 64'(bus.free_adr), 64'd3);

      // Random backpressure over 10 words
      push_event(11'd13, 32'h0000_0005);
      wait_done(600, 1'b1);
      chk("bp_data", 64'(ev_data), 64'd10);
      chk("bp_free", 64'(bus.free_adr), 64'd13);

      // Reset while the 3rd of 8 data words is pending
      p0 = pops;
      push_event(11'd21, 32'h0000_0006);
      reached = 1'b0;
      for (int i = 0; i < 200 && !reached; i++) begin
         if (ev_data >= 2) reached = 1'b1;
         else tick();
      end
      chk("mid_reached", 64'(ev_data), 64'd2);
      reset = 1'b1;
      tick();
      chk("mid_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_busy",      64'(bus.busy),      64'd0);
      chk("mid_fq_pop",    64'(bus.fq_pop),    64'd0);
      chk("mid_free",      64'(bus.free_adr),  64'd0);
      chk("mid_pops",      64'(pops - p0),     64'd0);
      exp_q.delete();
      fq.delete();
      fq_drive();
      exp_start = '0;
      tick();
      reset = 1'b0;
      tick();

      // Three queued events back to back
      p0 = pops; h0 = hdrs;
      push_event(11'd5,  32'h0000_0007);
      push_event(11'd5,  32'h0000_0008);
      push_event(11'd12, 32'h0000_0009);
      wait_done(300, 1'b0);
      chk("tri_hdrs", 64'(hdrs - h0), 64'd3);
      chk("tri_pops", 64'(pops - p0), 64'd3);
      chk("tri_free", 64'(bus.free_adr), 64'd12);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/buffer_readout.md
BUFFER_READOUT -- requirements
Module: buffer_readout

Interface
REQ-001 Parameter ADRB, default 11, raw hits buffer address bits.
REQ-002 Parameter DATAW, default 32, raw hits word width; SHALL be at least 32.
REQ-003 Parameter FQW, default ADRB+32, fence queue entry width: [ADRB-1:0] fence address (exclusive end), [FQW-1:ADRB] 32-bit event tag.
REQ-004 clock  in  1  single clock for the whole block.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 fq_empty  in  1  fence queue empty.
REQ-007 fq_rd_data  in  FQW  fence queue head entry.
REQ-008 fq_pop  out  1  single-cycle pop strobe to the fence queue.
REQ-009 buf_rd_en  out  1  raw hits RAM read enable.
REQ-010 buf_rd_adr  out  ADRB  raw hits RAM read address.
REQ-011 buf_rd_data  in  DATAW  raw hits RAM data, valid 1 cycle after buf_rd_en.
REQ-012 out_data  out  DATAW  readout word.
REQ-013 out_valid  out  1  out_data valid.
REQ-014 out_ready  in  1  downstream accepts when out_valid && out_ready.
REQ-015 out_first  out  1  marks the header word.
REQ-016 out_last  out  1  marks the final word of an event.
REQ-017 free_adr  out  ADRB  oldest unreleased buffer address; writer may fill up to it.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 sump  out  1  OR-reduction of unused inputs.

Function
REQ-020 FSM states: IDLE, SETTLE, LATCH, HDR, DATA, POP.
REQ-021 IDLE -> SETTLE when fq_empty=0; SETTLE -> LATCH unconditionally (one cycle of fence queue RAM read latency).
REQ-022 LATCH captures fence=fq_rd_data[ADRB-1:0] and tag; computes len=(fence-start_adr) mod 2^ADRB, where start_adr is an internal register; then -> HDR.
REQ-023 HDR presents out_data={zero-extend, tag}, out_first=1, out_last=(len==0), and holds until accepted; -> DATA if len!=0, else -> POP.
REQ-024 DATA reads addresses start_adr through fence-1, wrapping modulo 2^ADRB, and emits each word in address order with out_last on the word at fence-1.
REQ-025 DATA prefetch: a read is issued only when skid occupancy plus reads in flight is less than 2. With out_ready held at 1, output is sustained at one word per cycle.
REQ-026 out_data, out_first and out_last SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 On acceptance of the out_last word -> POP: assert fq_pop for exactly one cycle, set start_adr=fence and free_adr=fence, then -> IDLE.
REQ-028 fq_pop is never asserted while fq_empty=1; at most one pop per event.
REQ-029 After POP the block re-enters IDLE and SETTLE before sampling again, giving at least 2 cycles between a pop and the next LATCH.
REQ-030 Back-to-back events are read without loss. free_adr advances only at event completion, never mid-event.
REQ-031 When fence equals start_adr, the event is header-only; it is never treated as a full buffer.

Reset
REQ-032 Reset sets the state to IDLE, start_adr=0, free_adr=0, flushes the skid buffer and reads in flight, and sets fq_pop=0, buf_rd_en=0, out_valid=0, out_first=0, out_last=0, busy=0.
REQ-033 A reset asserted mid-event abandons the event without popping the fence queue; readout restarts from address 0.

Structure
REQ-034 FSM state encodings and the header-word format SHALL be constants in the shared readout package.
REQ-035 A 2-entry skid buffer sub-module, readout_skid (push/pop/full/empty, width DATAW+2), holds words returned by the RAM.

Verification
REQ-036 Single event: start=0, fence=4, tag=0xA5A5_0001, ready=1 -> header, then words at addresses 0..3; out_last on the 4th data word; one fq_pop; free_adr=4.
REQ-037 Wrap: start=2045 (ADRB=11), fence=3 -> data addresses 2045, 2046, 2047, 0, 1, 2 (6 words); free_adr=3.
REQ-038 Zero length: fence=start -> one word with out_first=1 and out_last=1; fq_pop after acceptance.
REQ-039 Backpressure: out_ready toggles randomly over a 10-word event -> all 10 words in order, no duplicates, outputs stable while stalled, at most 2 reads outstanding.
REQ-040 Reset asserted during DATA word 3 of 8 -> next cycle state is IDLE, out_valid=0, no fq_pop, free_adr=0.
REQ-041 Three queued events with ready=1 -> 3 headers, 3 pops, free_adr equals the last fence; no LATCH within 2 cycles after any pop.
